// File: rtl/mem_responder_riscv_if.sv
// Request/response bus between the RISC-V datapath and the memory responder.
interface mem_responder_riscv_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  // Requester side (datapath / control FSM)
  modport master (
    output req, we, addr, wdata, funct3,
    input  rdata, ready, err, busy
  );

  // Responder side
  modport slave (
    input  req, we, addr, wdata, funct3,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/mem_responder_riscv.sv
// Memory-side responder: word RAM plus two GPIO registers, sized lanes,
// programmable wait states, one-cycle ready pulse.
module mem_responder_riscv #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] IO_OUT_ADDR = 32'h1001_0024,
  parameter logic [31:0] IO_IN_ADDR  = 32'h1001_0028
) (
  input  logic                        clk,
  input  logic                        rst,
  mem_responder_riscv_if.slave        bus,
  input  logic [31:0]                 gpio_in,
  output logic [31:0]                 gpio_out
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WS_INIT   = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_err_q;
  logic [31:0] r_rdata;
  logic        r_ready;
  logic        r_err;
  logic        r_busy;
  logic [31:0] r_gpio_out;
  logic [31:0] r_sync1;
  logic [31:0] r_sync2;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_code_bad;
  logic        w_misal;
  logic        w_req_io;
  logic        w_req_ram;
  logic        w_req_err;
  logic        w_sel_io_in;
  logic        w_sel_io_out;
  logic [AW-1:0] w_idx;
  logic [31:0] w_old_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;
  logic [3:0]  w_bmask;
  logic [31:0] w_wrep;
  logic [31:0] w_merged;
  logic        w_ram_we;

  // Classify the incoming request so errors can short-circuit to RESP
  always_comb begin
    w_code_bad = 1'b0;
    w_misal    = 1'b0;
    w_req_io   = 1'b0;
    w_req_ram  = 1'b0;
    w_req_err  = 1'b0;
    w_code_bad = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) ||
                 (bus.funct3 == 3'b111) || (bus.we && bus.funct3[2]);
    w_misal    = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                 ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    w_req_io   = (bus.addr[31:2] == IO_OUT_ADDR[31:2]) ||
                 (bus.addr[31:2] == IO_IN_ADDR[31:2]);
    w_req_ram  = (bus.addr < RAM_BYTES);
    w_req_err  = w_code_bad || w_misal || !(w_req_io || w_req_ram);
  end

  // Lane extraction, load extension and store merge for the latched request
  always_comb begin
    w_sel_io_in  = (r_addr[31:2] == IO_IN_ADDR[31:2]);
    w_sel_io_out = (r_addr[31:2] == IO_OUT_ADDR[31:2]);
    w_idx        = r_addr[AW+1:2];
    w_old_word   = r_mem[w_idx];
    if (w_sel_io_in) begin
      w_old_word = r_sync2;
    end else if (w_sel_io_out) begin
      w_old_word = r_gpio_out;
    end

    case (r_addr[1:0])
      2'd0:    w_byte = w_old_word[7:0];
      2'd1:    w_byte = w_old_word[15:8];
      2'd2:    w_byte = w_old_word[23:16];
      default: w_byte = w_old_word[31:24];
    endcase
    w_half = r_addr[1] ? w_old_word[31:16] : w_old_word[15:0];

    case (r_funct3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'd0, w_byte};
      3'b101:  w_load_val = {16'd0, w_half};
      default: w_load_val = w_old_word;
    endcase

    case (r_funct3[1:0])
      2'b00: begin
        w_bmask = 4'(4'b0001 << r_addr[1:0]);
        w_wrep  = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_bmask = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wrep  = {2{r_wdata[15:0]}};
      end
      default: begin
        w_bmask = 4'b1111;
        w_wrep  = r_wdata;
      end
    endcase

    w_merged = w_old_word;
    for (int i = 0; i < 4; i++) begin
      if (w_bmask[i]) begin
        w_merged[8*i +: 8] = w_wrep[8*i +: 8];
      end
    end

    w_ram_we = (r_state == S_ACCESS) && r_we && !w_sel_io_in && !w_sel_io_out;
  end

  // Free-running two-flop synchronizer for the external GPIO input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 32'd0;
      r_sync2 <= 32'd0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end

  // RAM word write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // Request FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= 32'd0;
      r_we       <= 1'b0;
      r_wdata    <= 32'd0;
      r_funct3   <= 3'd0;
      r_err_q    <= 1'b0;
      r_rdata    <= 32'd0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_gpio_out <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= bus.req;
          if (bus.req) begin
            r_addr   <= bus.addr;
            r_we     <= bus.we;
            r_wdata  <= bus.wdata;
            r_funct3 <= bus.funct3;
            if (w_req_err) begin
              r_err_q <= 1'b1;
              r_rdata <= 32'd0;
              r_state <= S_RESP;
            end else begin
              r_err_q <= 1'b0;
              if (WAIT_STATES == 0) begin
                r_state <= S_ACCESS;
              end else begin
                r_cnt   <= WS_INIT;
                r_state <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_ACCESS;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          r_state <= S_RESP;
          if (r_we) begin
            if (w_sel_io_in) begin
              r_err_q <= 1'b1;
            end else if (w_sel_io_out) begin
              r_gpio_out <= w_merged;
            end
          end else begin
            r_rdata <= w_load_val;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_err   <= r_err_q;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  assign bus.busy  = r_busy;
  assign gpio_out  = r_gpio_out;

endmodule
